// File: rtl/spi_flash_emu_pkg.sv
// Shared opcodes, FSM states and default identity for the SPI flash
// emulator.
package spi_flash_emu_pkg;

    localparam logic [7:0]  OpRead     = 8'h03;
    localparam logic [7:0]  OpRdid     = 8'h9F;
    localparam logic [7:0]  OpRdsr     = 8'h05;
    localparam logic [23:0] DefJedecId = 24'hEF4018;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        STATUS,
        IGNORE
    } state_e;

endpackage

// File: rtl/spi_flash_emu_sync.sv
// Brings SCK/CSB/MOSI into clk_i and turns SCK into rise/fall pulses.
// CSB resets high so the target comes out of reset deselected.
module spi_flash_emu_sync #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sck_i,
    input  logic csb_i,
    input  logic sd_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic csb_o,
    output logic sd_o
);

    logic [SyncStages-1:0] sck_q;
    logic [SyncStages-1:0] csb_q;
    logic [SyncStages-1:0] sd_q;
    logic                  sck_prev_q;
    logic                  sck_s;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sck_q      <= '0;
            csb_q      <= '1;
            sd_q       <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_q      <= {sck_q[SyncStages-2:0], sck_i};
            csb_q      <= {csb_q[SyncStages-2:0], csb_i};
            sd_q       <= {sd_q[SyncStages-2:0], sd_i};
            sck_prev_q <= sck_s;
        end
    end

    assign sck_s      = sck_q[SyncStages-1];
    assign sck_rise_o = sck_s & ~sck_prev_q;
    assign sck_fall_o = ~sck_s & sck_prev_q;
    assign csb_o      = csb_q[SyncStages-1];
    assign sd_o       = sd_q[SyncStages-1];

endmodule

// File: rtl/spi_flash_emu.sv
// SPI mode-0 NOR flash target: decodes READ/RDID/RDSR and streams READ
// bytes from a req/gnt/rvalid byte memory through a one-byte prefetch.
module spi_flash_emu
    import spi_flash_emu_pkg::*;
#(
    parameter int unsigned AddrWidth  = 24,
    parameter int unsigned SyncStages = 2,
    parameter logic [23:0] JedecId    = DefJedecId
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 spi_sck_i,
    input  logic                 spi_csb_i,
    input  logic                 spi_sd_i,
    output logic                 spi_sd_o,
    output logic                 spi_sd_en_o,
    output logic                 mem_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [7:0]           mem_rdata_i,
    output logic                 busy_o,
    output logic                 underrun_o
);

    localparam int unsigned CntW = $clog2(AddrWidth > 8 ? AddrWidth : 8);

    logic sck_rise, sck_fall, csb_s, sd_s;

    spi_flash_emu_sync #(
        .SyncStages(SyncStages)
    ) u_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .sck_i     (spi_sck_i),
        .csb_i     (spi_csb_i),
        .sd_i      (spi_sd_i),
        .sck_rise_o(sck_rise),
        .sck_fall_o(sck_fall),
        .csb_o     (csb_s),
        .sd_o      (sd_s)
    );

    state_e               state_q, state_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]           out_cnt_q, out_cnt_d;
    logic [1:0]           id_idx_q, id_idx_d;
    logic [AddrWidth-1:0] sh_in_q, sh_in_d, sh_in_next;
    logic [AddrWidth-1:0] fetch_q, fetch_d;
    logic [AddrWidth-1:0] req_addr_q, req_addr_d;
    logic [7:0]           sh_out_q, sh_out_d;
    logic [7:0]           buf_q, buf_d;
    logic [7:0]           load_byte, id_byte;
    logic                 en_q, en_d;
    logic                 req_q, req_d;
    logic                 wait_q, wait_d;
    logic                 disc_q, disc_d;
    logic                 want_q, want_d;
    logic                 buf_vld_q, buf_vld_d;
    logic                 underrun_q, underrun_d;
    logic                 shifting, load, rv_take;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bit_cnt_q  <= '0;
            out_cnt_q  <= '0;
            id_idx_q   <= '0;
            sh_in_q    <= '0;
            fetch_q    <= '0;
            req_addr_q <= '0;
            sh_out_q   <= '0;
            buf_q      <= '0;
            en_q       <= 1'b0;
            req_q      <= 1'b0;
            wait_q     <= 1'b0;
            disc_q     <= 1'b0;
            want_q     <= 1'b0;
            buf_vld_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            out_cnt_q  <= out_cnt_d;
            id_idx_q   <= id_idx_d;
            sh_in_q    <= sh_in_d;
            fetch_q    <= fetch_d;
            req_addr_q <= req_addr_d;
            sh_out_q   <= sh_out_d;
            buf_q      <= buf_d;
            en_q       <= en_d;
            req_q      <= req_d;
            wait_q     <= wait_d;
            disc_q     <= disc_d;
            want_q     <= want_d;
            buf_vld_q  <= buf_vld_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        unique case (id_idx_q)
            2'd0:    id_byte = JedecId[23:16];
            2'd1:    id_byte = JedecId[15:8];
            2'd2:    id_byte = JedecId[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        out_cnt_d  = out_cnt_q;
        id_idx_d   = id_idx_q;
        sh_in_d    = sh_in_q;
        fetch_d    = fetch_q;
        req_addr_d = req_addr_q;
        sh_out_d   = sh_out_q;
        buf_d      = buf_q;
        en_d       = en_q;
        req_d      = req_q;
        wait_d     = wait_q;
        disc_d     = disc_q;
        want_d     = want_q;
        buf_vld_d  = buf_vld_q;
        underrun_d = underrun_q;
        load_byte  = 8'h00;
        sh_in_next = {sh_in_q[AddrWidth-2:0], sd_s};
        shifting   = state_q inside {DATA, ID, STATUS};
        load       = shifting && sck_fall && (out_cnt_q == 3'd0);
        rv_take    = mem_rvalid_i && wait_q && !disc_q
                     && (state_q == DATA) && !csb_s;

        if (req_q && mem_gnt_i) begin
            req_d  = 1'b0;
            wait_d = 1'b1;
        end
        if (wait_q && mem_rvalid_i) begin
            wait_d = 1'b0;
            disc_d = 1'b0;
        end
        if (want_q && !req_q && !wait_q && !csb_s) begin
            req_d      = 1'b1;
            req_addr_d = fetch_q;
            fetch_d    = fetch_q + AddrWidth'(1);
            want_d     = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!csb_s) state_d = CMD;
            end
            CMD: begin
                if (sck_rise) begin
                    sh_in_d   = sh_in_next;
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                    if (bit_cnt_q == CntW'(7)) begin
                        bit_cnt_d = '0;
                        unique case (sh_in_next[7:0])
                            OpRead:  state_d = ADDR;
                            OpRdid:  state_d = ID;
                            OpRdsr:  state_d = STATUS;
                            default: state_d = IGNORE;
                        endcase
                    end
                end
            end
            ADDR: begin
                if (sck_rise) begin
                    sh_in_d   = sh_in_next;
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                    if (bit_cnt_q == CntW'(AddrWidth - 1)) begin
                        bit_cnt_d = '0;
                        fetch_d   = sh_in_next;
                        want_d    = 1'b1;
                        state_d   = DATA;
                    end
                end
            end
            default: ;
        endcase

        if (shifting && sck_fall) begin
            out_cnt_d = out_cnt_q + 3'd1;
            sh_out_d  = {sh_out_q[6:0], 1'b0};
            if (load) begin
                en_d = 1'b1;
                if (state_q == ID) begin
                    load_byte = id_byte;
                    if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
                end else if (state_q == DATA) begin
                    if (buf_vld_q) begin
                        load_byte = buf_q;
                        buf_vld_d = 1'b0;
                        want_d    = 1'b1;
                    end else if (rv_take) begin
                        load_byte = mem_rdata_i;
                        want_d    = 1'b1;
                    end else begin
                        load_byte  = 8'hFF;
                        underrun_d = 1'b1;
                    end
                end
                sh_out_d = load_byte;
            end
        end

        // Data arriving on the load cycle with an empty buffer went straight out.
        if (rv_take && !(load && !buf_vld_q)) begin
            buf_d     = mem_rdata_i;
            buf_vld_d = 1'b1;
        end

        if (csb_s) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            out_cnt_d = '0;
            id_idx_d  = '0;
            en_d      = 1'b0;
            want_d    = 1'b0;
            buf_vld_d = 1'b0;
            if (req_q || (wait_q && !mem_rvalid_i)) disc_d = 1'b1;
        end
    end

    assign spi_sd_o    = sh_out_q[7];
    assign spi_sd_en_o = en_q;
    assign mem_req_o   = req_q;
    assign mem_addr_o  = req_addr_q;
    assign busy_o      = ~csb_s;
    assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_spi_flash_emu.sv
// Directed bench for spi_flash_emu: SPI frames at f_clk/8 against a byte
// memory model with programmable grant delay.
`timescale 1ns/1ps
module tb_spi_flash_emu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        spi_sck_i;
    logic        spi_csb_i;
    logic        spi_sd_i;
    logic        spi_sd_o;
    logic        spi_sd_en_o;
    logic        mem_req_o;
    logic [23:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [7:0]  mem_rdata_i;
    logic        busy_o;
    logic        underrun_o;

    int          checks = 0;
    int          errors = 0;
    int          gnt_delay = 0;
    int          wait_cnt;
    logic        pend;
    logic [7:0]  pend_data;
    logic [23:0] addr_log[$];

    always #5 clk_i = ~clk_i;

    spi_flash_emu dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .spi_sck_i   (spi_sck_i),
        .spi_csb_i   (spi_csb_i),
        .spi_sd_i    (spi_sd_i),
        .spi_sd_o    (spi_sd_o),
        .spi_sd_en_o (spi_sd_en_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o),
        .underrun_o  (underrun_o)
    );

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000010: return 8'hA5;
            24'h000011: return 8'h5A;
            24'h000012: return 8'h01;
            24'h000013: return 8'hFE;
            24'hFFFFFF: return 8'hC3;
            24'h000000: return 8'h3C;
            default:    return a[7:0] ^ 8'h66;
        endcase
    endfunction

    // Memory responder: grant after gnt_delay cycles, rvalid one cycle later.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 8'h00;
            pend         = 1'b0;
            pend_data    = 8'h00;
            wait_cnt     = 0;
        end else begin
            mem_rvalid_i = pend;
            mem_rdata_i  = pend ? pend_data : 8'h00;
            pend         = 1'b0;
            mem_gnt_i    = 1'b0;
            if (mem_req_o) begin
                if (wait_cnt >= gnt_delay) begin
                    mem_gnt_i = 1'b1;
                    pend      = 1'b1;
                    pend_data = mem_byte(mem_addr_o);
                    addr_log.push_back(mem_addr_o);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic sck_bit(input logic mosi, output logic miso,
                           output logic en);
        spi_sd_i = mosi;
        repeat (4) @(negedge clk_i);
        miso = spi_sd_o;
        en   = spi_sd_en_o;
        spi_sck_i = 1'b1;
        repeat (4) @(negedge clk_i);
        spi_sck_i = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx,
                        output logic en_any);
        logic m, e;
        rx     = 8'h00;
        en_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            sck_bit(tx[i], m, e);
            rx[i]  = m;
            en_any = en_any | e;
        end
    endtask

    task automatic frame_begin();
        spi_csb_i = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk_i);
        spi_csb_i = 1'b1;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic read_hdr(input logic [23:0] a);
        logic [7:0] rx;
        logic       en;
        xfer(8'h03, rx, en);
        xfer(a[23:16], rx, en);
        xfer(a[15:8], rx, en);
        xfer(a[7:0], rx, en);
    endtask

    task automatic test_reset();
        rst_ni    = 1'b0;
        spi_csb_i = 1'b1;
        spi_sck_i = 1'b0;
        spi_sd_i  = 1'b0;
        repeat (4) @(negedge clk_i);
        checks++;
        if ({spi_sd_o, spi_sd_en_o, mem_req_o, mem_addr_o, busy_o,
             underrun_o} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got sd=%b en=%b req=%b addr=%h busy=%b und=%b required all 0",
                     spi_sd_o, spi_sd_en_o, mem_req_o, mem_addr_o,
                     busy_o, underrun_o);
        end
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_read();
        logic [7:0]  exp[4] = '{8'hA5, 8'h5A, 8'h01, 8'hFE};
        logic [7:0]  rx;
        logic        en;
        logic [23:0] got;
        addr_log.delete();
        frame_begin();
        read_hdr(24'h000010);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, rx, en);
            checks++;
            if (rx !== exp[i] || en !== 1'b1) begin
                errors++;
                $display("FAIL read_byte%0d: got %h en=%b required %h en=1",
                         i, rx, en, exp[i]);
            end
        end
        frame_end();
        for (int i = 0; i < 5; i++) begin
            got = (i < addr_log.size()) ? addr_log[i] : 24'hxxxxxx;
            checks++;
            if (got !== 24'h10 + 24'(i)) begin
                errors++;
                $display("FAIL read_addr%0d: got %h required %h",
                         i, got, 24'h10 + 24'(i));
            end
        end
        checks++;
        if (underrun_o !== 1'b0) begin
            errors++;
            $display("FAIL read_underrun: got %b required 0", underrun_o);
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  rx0, rx1;
        logic        en;
        logic [23:0] a0, a1;
        addr_log.delete();
        frame_begin();
        read_hdr(24'hFFFFFF);
        xfer(8'h00, rx0, en);
        xfer(8'h00, rx1, en);
        frame_end();
        a0 = (addr_log.size() > 0) ? addr_log[0] : 24'hxxxxxx;
        a1 = (addr_log.size() > 1) ? addr_log[1] : 24'hxxxxxx;
        checks++;
        if (a0 !== 24'hFFFFFF || a1 !== 24'h000000) begin
            errors++;
            $display("FAIL wrap_addr: got %h,%h required ffffff,000000",
                     a0, a1);
        end
        checks++;
        if (rx0 !== 8'hC3 || rx1 !== 8'h3C) begin
            errors++;
            $display("FAIL wrap_data: got %h,%h required c3,3c", rx0, rx1);
        end
    endtask

    task automatic test_id_status();
        logic [7:0] exp[4] = '{8'hEF, 8'h40, 8'h18, 8'h00};
        logic [7:0] rx;
        logic       en;
        frame_begin();
        xfer(8'h9F, rx, en);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, rx, en);
            checks++;
            if (rx !== exp[i]) begin
                errors++;
                $display("FAIL rdid_byte%0d: got %h required %h",
                         i, rx, exp[i]);
            end
        end
        frame_end();
        frame_begin();
        xfer(8'h05, rx, en);
        xfer(8'hFF, rx, en);
        frame_end();
        checks++;
        if (rx !== 8'h00 || en !== 1'b1) begin
            errors++;
            $display("FAIL rdsr: got %h en=%b required 00 en=1", rx, en);
        end
        frame_begin();
        xfer(8'hAB, rx, en);
        xfer(8'h00, rx, en);
        frame_end();
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL ignore_en: got %b required 0", en);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] rx;
        logic       en;
        gnt_delay = 40;
        frame_begin();
        read_hdr(24'h000030);
        xfer(8'h00, rx, en);
        frame_end();
        gnt_delay = 0;
        repeat (20) @(negedge clk_i);
        checks++;
        if (rx !== 8'hFF) begin
            errors++;
            $display("FAIL underrun_byte: got %h required ff", rx);
        end
        checks++;
        if (underrun_o !== 1'b1) begin
            errors++;
            $display("FAIL underrun_flag: got %b required 1", underrun_o);
        end
    endtask

    task automatic test_abort();
        logic [7:0] rx0, rx1;
        logic       m, en;
        gnt_delay = 40;
        frame_begin();
        read_hdr(24'h000020);
        for (int i = 0; i < 3; i++) sck_bit(1'b0, m, en);
        frame_end();
        checks++;
        if (busy_o !== 1'b0 || spi_sd_en_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b en=%b required 0,0",
                     busy_o, spi_sd_en_o);
        end
        gnt_delay = 0;
        repeat (20) @(negedge clk_i);
        frame_begin();
        read_hdr(24'h000000);
        xfer(8'h00, rx0, en);
        xfer(8'h00, rx1, en);
        frame_end();
        checks++;
        if (rx0 !== 8'h3C || rx1 !== 8'h67) begin
            errors++;
            $display("FAIL abort_next_read: got %h,%h required 3c,67",
                     rx0, rx1);
        end
        checks++;
        if (underrun_o !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky: got %b required 1", underrun_o);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        logic       m, en;
        frame_begin();
        read_hdr(24'h000010);
        xfer(8'h00, rx, en);
        for (int i = 0; i < 3; i++) sck_bit(1'b1, m, en);
        rst_ni = 1'b0;
        repeat (4) @(negedge clk_i);
        checks++;
        if ({spi_sd_o, spi_sd_en_o, mem_req_o, mem_addr_o, busy_o,
             underrun_o} !== 29'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got sd=%b en=%b req=%b addr=%h busy=%b und=%b required all 0",
                     spi_sd_o, spi_sd_en_o, mem_req_o, mem_addr_o,
                     busy_o, underrun_o);
        end
        rst_ni    = 1'b1;
        spi_csb_i = 1'b1;
        repeat (8) @(negedge clk_i);
        frame_begin();
        xfer(8'h9F, rx, en);
        xfer(8'h00, rx, en);
        frame_end();
        checks++;
        if (rx !== 8'hEF) begin
            errors++;
            $display("FAIL midreset_rdid: got %h required ef", rx);
        end
        checks++;
        if (underrun_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_underrun: got %b required 0",
                     underrun_o);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_wrap();
        test_id_status();
        test_underrun();
        test_abort();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
